// File: rtl/mem_arbiter.sv
// Three-way arbiter (DMA fixed-high, fetch/data round-robin) for the single addr_interpreter port.
// Optional ISSUE watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_addr,
  input  logic        if_ren,
  output logic        if_ack,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data_i,
  input  logic        dm_ren,
  input  logic        dm_wen,
  output logic        dm_ack,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_data_i,
  input  logic        dma_ren,
  input  logic        dma_wen,
  output logic        dma_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic        mem_ack,
  input  logic [31:0] mem_data_o,
  output logic [1:0]  grant,
  output logic [2:0]  arb_state,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    ISSUE   = 3'b010,
    RELEASE = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2,
    GNT_DMA  = 2'd3
  } grant_t;

  state_t      state, state_n;
  grant_t      grant_q, grant_n, winner;
  logic        rr, rr_n;  // 0: fetch favoured on the next tie, 1: data port favoured
  logic [31:0] addr_n, wdata_n, rdata_n;
  logic        ren_n, wen_n, done_n, terr_n;
  logic        if_ack_n, dm_ack_n, dma_ack_n;
  logic        timeout_hit;

  assign grant = grant_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tcnt;

  // Held at zero outside ISSUE, so every new transaction starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state != ISSUE) begin
      tcnt <= '0;
    end else if (!mem_ack) begin
      tcnt <= tcnt + 16'd1;
    end
  end

  assign timeout_hit = (state == ISSUE) && (tcnt == TO_LAST);
`else
  // No watchdog in this build: ISSUE waits for mem_ack indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    winner = GNT_NONE;
    if (dma_ren || dma_wen) begin
      winner = GNT_DMA;
    end else if (if_ren && (dm_ren || dm_wen)) begin
      winner = rr ? GNT_DM : GNT_IF;
    end else if (if_ren) begin
      winner = GNT_IF;
    end else if (dm_ren || dm_wen) begin
      winner = GNT_DM;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path through the case infers a latch.
    state_n = state;
    grant_n = grant_q;
    rr_n    = rr;
    addr_n  = mem_addr;
    wdata_n = mem_data_i;
    ren_n   = mem_ren;
    wen_n   = mem_wen;
    rdata_n = rdata;
    done_n  = 1'b0;
    terr_n  = 1'b0;

    case (state)
      IDLE: begin
        if (winner != GNT_NONE) begin
          grant_n = winner;
          state_n = ISSUE;
          case (winner)
            GNT_IF: begin
              addr_n  = if_addr;
              wdata_n = '0;
              ren_n   = 1'b1;
              wen_n   = 1'b0;
              rr_n    = 1'b1;
            end
            GNT_DM: begin
              addr_n  = dm_addr;
              wdata_n = dm_data_i;
              ren_n   = dm_ren;
              wen_n   = dm_wen & ~dm_ren;
              rr_n    = 1'b0;
            end
            default: begin
              addr_n  = dma_addr;
              wdata_n = dma_data_i;
              ren_n   = dma_ren;
              wen_n   = dma_wen & ~dma_ren;
            end
          endcase
        end
      end

      ISSUE: begin
        // A real completion takes precedence over a watchdog expiring in the same cycle.
        if (mem_ack) begin
          rdata_n = mem_data_o;
          done_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          state_n = RELEASE;
        end else if (timeout_hit) begin
          rdata_n = ERR_DATA;
          done_n  = 1'b1;
          terr_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          state_n = RELEASE;
        end
      end

      RELEASE: begin
        ren_n = 1'b0;
        wen_n = 1'b0;
        if (!mem_ack) begin
          grant_n = GNT_NONE;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = GNT_NONE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase

    if_ack_n  = done_n && (grant_q == GNT_IF);
    dm_ack_n  = done_n && (grant_q == GNT_DM);
    dma_ack_n = done_n && (grant_q == GNT_DMA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      grant_q     <= GNT_NONE;
      rr          <= 1'b0;
      arb_state   <= '0;
      mem_addr    <= '0;
      mem_data_i  <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      rdata       <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant_q     <= grant_n;
      rr          <= rr_n;
      arb_state   <= state_n;
      mem_addr    <= addr_n;
      mem_data_i  <= wdata_n;
      mem_ren     <= ren_n;
      mem_wen     <= wen_n;
      rdata       <= rdata_n;
      if_ack      <= if_ack_n;
      dm_ack      <= dm_ack_n;
      dma_ack     <= dma_ack_n;
      timeout_err <= terr_n;
    end
  end

endmodule
